seq_run_controller: RTL and testbench
=====================================

Name: seq_run_controller

Overview:
Run-level scheduler for the four-channel pulse sequencer. It drives the sequencer's shared reset and operate controls so that a programmed number of runs executes, each run a fixed number of cycles. Runs start on command or on an external trigger edge, with an optional idle gap between runs. It sits between the host register block and the sequencer, replacing manual toggling of the sequencer's operate and reset config bits.

Parameters:
CNT_W, 32, width of run_length and gap_length and their internal counters
REP_W, 16, width of repeat_count and runs_completed
RESET_CYCLES, 2, cycles seq_reset is held high before each run (legal values are 1 or greater)

Ports:
clk  in  1  sequencer clock
reset  in  1  synchronous, active-high
start  in  1  single-cycle start request
abort  in  1  single-cycle abort request
trig_in  in  1  external trigger level
use_trig  in  1  1 = each run waits for a trig_in rising edge
run_length  in  CNT_W  operate cycles per run
gap_length  in  CNT_W  idle cycles between runs
repeat_count  in  REP_W  runs per sequence; 0 = run until abort
seq_reset  out  1  drives the sequencer's reset
seq_operate  out  1  drives the sequencer's operate
busy  out  1  high whenever state is not IDLE
run_done  out  1  1-cycle pulse after each completed run
all_done  out  1  1-cycle pulse after the final run
aborted  out  1  1-cycle pulse on an accepted abort
runs_completed  out  REP_W  runs finished in the current sequence
state  out  3  IDLE=0, ARM=1, PRERST=2, RUN=3, GAP=4

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Every output is registered. On reset: state=IDLE, all outputs 0, all counters 0, trigger edge history 0.
- IDLE: start with run_length!=0 latches run_length, gap_length, repeat_count and use_trig, clears runs_completed, and moves to ARM next cycle. start with run_length==0 is ignored.
- Input changes after a start has been accepted have no effect until the next accepted start.
- ARM:
  - use_trig=0: the block spends exactly 1 cycle in ARM, then goes to PRERST.
  - use_trig=1: it waits for a rising edge (trig_in=0 in the previous cycle, 1 in this cycle). An edge in cycle t gives PRERST in t+1.
  - Edges outside ARM are discarded, not queued.
- PRERST: seq_reset=1 for exactly RESET_CYCLES cycles, then RUN.
- RUN: seq_operate=1 for exactly run_length cycles.
  - The end of RUN increments runs_completed (saturating at all ones). run_done=1 in the first cycle after the last operate cycle.
  - If repeat_count!=0 and the incremented count equals repeat_count: go to IDLE, with all_done=1 in the same cycle as run_done. No GAP is inserted.
  - Otherwise, if gap_length!=0, go to GAP. If gap_length==0, go directly to ARM.
- GAP: seq_operate=0 and seq_reset=0 for exactly gap_length cycles, then ARM.
- seq_reset and seq_operate are never high in the same cycle. Both are 0 in IDLE, ARM and GAP.
- abort outside IDLE, from any state:
  - Next cycle: state=IDLE, seq_operate=0, seq_reset=0, aborted=1.
  - No run_done or all_done pulse. runs_completed holds its value.
- abort in IDLE has no effect and produces no pulse. If abort and start arrive in the same cycle, abort wins and start is ignored.
- start while busy is ignored.
- repeat_count=0: runs repeat indefinitely. runs_completed saturates, and all_done never fires.
- Counters are CNT_W-bit down-counters loaded from the latched values. There is no wrap: the maximum run_length gives exactly 2^CNT_W-1 operate cycles.

Optional Feature:
SEQ_RUN_TRIG_SYNC_EN
- Defined: trig_in passes through a 2-flop synchroniser before edge detection. Trigger-to-PRERST latency becomes 3 cycles from the trig_in rise.
- Undefined: trig_in is treated as already synchronous to clk. Latency is 1 cycle, as specified in Behaviour.

Test Plan:
- start, use_trig=0, run_length=5, gap_length=3, repeat_count=2, RESET_CYCLES=2 -> per run: ARM 1 cycle, seq_reset 2 cycles, seq_operate 5 cycles. GAP of 3 cycles between the runs only. Two run_done pulses; all_done coincides with the second. runs_completed ends at 2; busy ends at 0.
- use_trig=1, run_length=4, repeat_count=1; hold trig_in high before start, then pulse it low and high in ARM -> no run on the stale high level. PRERST starts 1 cycle after the rising edge. Exactly 4 operate cycles follow.
- repeat_count=0, run_length=3, gap_length=0; abort during the third RUN -> seq_operate=0 and aborted=1 the next cycle. state=IDLE, runs_completed=2, no all_done.
- start with run_length=0 -> state stays IDLE, busy=0, no pulses. Then start and abort in the same cycle with run_length=3 -> stays IDLE, aborted=0.
- reset asserted mid-RUN (run_length=100) -> next cycle all outputs are 0 and state=IDLE. A following start runs a full 100-cycle run.
- SEQ_RUN_TRIG_SYNC_EN defined, use_trig=1 -> PRERST begins exactly 3 cycles after the trig_in rise. A 1-cycle-wide trigger pulse is still detected.

Source files
------------

// File: rtl/seq_run_controller.sv
// seq_run_controller: run-level scheduler for the four-channel pulse sequencer.
// It drives the sequencer's shared reset (seq_reset) and operate (seq_operate)
// controls. A programmed number of runs executes. Each run is one ARM phase,
// then RESET_CYCLES of seq_reset, then run_length cycles of seq_operate.
// An optional GAP of idle cycles separates consecutive runs.
//
// Build option: define SEQ_RUN_TRIG_SYNC_EN to pass trig_in through a
// 2-flop synchroniser before rising-edge detection. This makes the
// trigger-to-PRERST latency 3 cycles instead of 1.
//
// Request semantics: start and abort are single-cycle requests with no
// back-pressure. A request is acted on in the cycle it is high or it is
// dropped. start is accepted only in IDLE with a non-zero run_length and no
// abort in the same cycle. abort is accepted in any state other than IDLE.
// The FSM state is exposed on the state output for observation.

module seq_run_controller #(
  parameter int CNT_W        = 32,
  parameter int REP_W        = 16,
  parameter int RESET_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             trig_in,
  input  logic             use_trig,
  input  logic [CNT_W-1:0] run_length,
  input  logic [CNT_W-1:0] gap_length,
  input  logic [REP_W-1:0] repeat_count,
  output logic             seq_reset,
  output logic             seq_operate,
  output logic             busy,
  output logic             run_done,
  output logic             all_done,
  output logic             aborted,
  output logic [REP_W-1:0] runs_completed,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_PRERST = 3'd2,
    ST_RUN    = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  // Down-counter reload for the reset phase: it counts RESET_CYCLES-1 .. 0.
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] run_len_q;
  logic [CNT_W-1:0] gap_len_q;
  logic [REP_W-1:0] rep_q;
  logic             use_trig_q;
  logic [REP_W-1:0] runs_next;
  logic             trig_prev;
  logic             trig_edge;

  assign state = state_q;

  // The completed-run count saturates at all ones.
  assign runs_next = (&runs_completed) ? runs_completed
                                       : runs_completed + REP_W'(1);

`ifdef SEQ_RUN_TRIG_SYNC_EN
  logic trig_s1;
  logic trig_s2;

  // Two-flop synchroniser plus edge history for an asynchronous trigger.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_s1   <= 1'b0;
      trig_s2   <= 1'b0;
      trig_prev <= 1'b0;
    end else begin
      trig_s1   <= trig_in;
      trig_s2   <= trig_s1;
      trig_prev <= trig_s2;
    end
  end

  assign trig_edge = trig_s2 & ~trig_prev;
`else
  // Edge history for a trigger that is already synchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_prev <= 1'b0;
    end else begin
      trig_prev <= trig_in;
    end
  end

  assign trig_edge = trig_in & ~trig_prev;
`endif

  // Run scheduler FSM. The outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt            <= '0;
      run_len_q      <= '0;
      gap_len_q      <= '0;
      rep_q          <= '0;
      use_trig_q     <= 1'b0;
      seq_reset      <= 1'b0;
      seq_operate    <= 1'b0;
      busy           <= 1'b0;
      run_done       <= 1'b0;
      all_done       <= 1'b0;
      aborted        <= 1'b0;
      runs_completed <= '0;
    end else begin
      run_done <= 1'b0;
      all_done <= 1'b0;
      aborted  <= 1'b0;
      if (abort && (state_q != ST_IDLE)) begin
        // An abort drops both sequencer controls at once. The run count holds.
        state_q     <= ST_IDLE;
        busy        <= 1'b0;
        seq_reset   <= 1'b0;
        seq_operate <= 1'b0;
        aborted     <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && !abort && (run_length != '0)) begin
              run_len_q      <= run_length;
              gap_len_q      <= gap_length;
              rep_q          <= repeat_count;
              use_trig_q     <= use_trig;
              runs_completed <= '0;
              busy           <= 1'b1;
              state_q        <= ST_ARM;
            end
          end
          ST_ARM: begin
            if (!use_trig_q || trig_edge) begin
              state_q   <= ST_PRERST;
              seq_reset <= 1'b1;
              cnt       <= RST_LOAD;
            end
          end
          ST_PRERST: begin
            if (cnt == '0) begin
              state_q     <= ST_RUN;
              seq_reset   <= 1'b0;
              seq_operate <= 1'b1;
              cnt         <= run_len_q - CNT_W'(1);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_RUN: begin
            if (cnt == '0) begin
              seq_operate    <= 1'b0;
              run_done       <= 1'b1;
              runs_completed <= runs_next;
              if ((rep_q != '0) && (runs_next == rep_q)) begin
                all_done <= 1'b1;
                busy     <= 1'b0;
                state_q  <= ST_IDLE;
              end else if (gap_len_q != '0) begin
                state_q <= ST_GAP;
                cnt     <= gap_len_q - CNT_W'(1);
              end else begin
                state_q <= ST_ARM;
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_GAP: begin
            if (cnt == '0) begin
              state_q <= ST_ARM;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            busy        <= 1'b0;
            seq_reset   <= 1'b0;
            seq_operate <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_run_controller.sv
// Testbench for seq_run_controller. A schedule-based reference model predicts
// the outputs for every cycle. When a run is planned, the model appends the
// phase of each future cycle to exp_q. A per-cycle compare process checks the
// DUT against that prediction. The directed tests add literal expectations.

module tb_seq_run_controller;

  localparam int CNT_W        = 32;
  localparam int REP_W        = 16;
  localparam int RESET_CYCLES = 2;

`ifdef SEQ_RUN_TRIG_SYNC_EN
  localparam int EXP_TRIG_LAT = 3;
`else
  localparam int EXP_TRIG_LAT = 1;
`endif

  localparam logic [2:0] P_IDLE = 3'd0, P_ARM = 3'd1, P_PRERST = 3'd2,
                         P_RUN = 3'd3, P_GAP = 3'd4, P_END = 3'd7;

  typedef struct packed {
    logic [2:0]       st;
    logic             rst;
    logic             op;
    logic             busy;
    logic             rd;
    logic             ad;
    logic             ab;
    logic [REP_W-1:0] rc;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             start, abort, trig_in, use_trig;
  logic [CNT_W-1:0] run_length, gap_length;
  logic [REP_W-1:0] repeat_count;
  logic             seq_reset, seq_operate, busy, run_done, all_done, aborted;
  logic [REP_W-1:0] runs_completed;
  logic [2:0]       state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  seq_run_controller #(
    .CNT_W(CNT_W), .REP_W(REP_W), .RESET_CYCLES(RESET_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .trig_in(trig_in), .use_trig(use_trig), .run_length(run_length),
    .gap_length(gap_length), .repeat_count(repeat_count),
    .seq_reset(seq_reset), .seq_operate(seq_operate), .busy(busy),
    .run_done(run_done), .all_done(all_done), .aborted(aborted),
    .runs_completed(runs_completed), .state(state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  logic [2:0]       exp_q[$];
  logic [2:0]       m_st;
  logic [REP_W-1:0] m_rc;
  logic             m_rd, m_ad, m_ab;
  logic [CNT_W-1:0] l_run, l_gap;
  logic [REP_W-1:0] l_rep;
  logic             l_trig;
  logic             h1, h2, h3;
  logic             m_valid = 1'b0;
  obs_t             m_exp;

  task automatic push_body();
    for (int i = 0; i < RESET_CYCLES; i++) exp_q.push_back(P_PRERST);
    for (int unsigned i = 0; i < l_run; i++) exp_q.push_back(P_RUN);
    exp_q.push_back(P_END);
  endtask

  task automatic push_next_run();
    exp_q.push_back(P_ARM);
    if (!l_trig) push_body();
  endtask

  task automatic model_step();
    logic       rise;
    logic [2:0] nxt;
    if (reset) begin
      exp_q.delete();
      m_st = P_IDLE; m_rc = '0; m_rd = 0; m_ad = 0; m_ab = 0;
      h1 = 0; h2 = 0; h3 = 0;
      m_valid = 1'b1;
    end else begin
`ifdef SEQ_RUN_TRIG_SYNC_EN
      rise = h2 & ~h3;
`else
      rise = trig_in & ~h1;
`endif
      h3 = h2; h2 = h1; h1 = trig_in;
      m_rd = 0; m_ad = 0; m_ab = 0;
      if (abort && m_st != P_IDLE) begin
        exp_q.delete();
        m_st = P_IDLE;
        m_ab = 1;
      end else begin
        if (m_st == P_IDLE && start && !abort && run_length != 0) begin
          l_run = run_length; l_gap = gap_length;
          l_rep = repeat_count; l_trig = use_trig;
          m_rc = '0;
          push_next_run();
        end else if (m_st == P_ARM && exp_q.size() == 0 && rise) begin
          push_body();
        end
        if (exp_q.size() != 0) begin
          nxt = exp_q.pop_front();
          if (nxt == P_END) begin
            m_rd = 1;
            if (m_rc != {REP_W{1'b1}}) m_rc = m_rc + 1'b1;
            if (l_rep != 0 && m_rc == l_rep) begin
              m_ad = 1;
              nxt  = P_IDLE;
            end else begin
              for (int unsigned i = 0; i < l_gap; i++) exp_q.push_back(P_GAP);
              push_next_run();
              nxt = exp_q.pop_front();
            end
          end
          m_st = nxt;
        end
      end
    end
    m_exp.st   = m_st;
    m_exp.rst  = (m_st == P_PRERST);
    m_exp.op   = (m_st == P_RUN);
    m_exp.busy = (m_st != P_IDLE);
    m_exp.rd   = m_rd;
    m_exp.ad   = m_ad;
    m_exp.ab   = m_ab;
    m_exp.rc   = m_rc;
  endtask

  // Compare the DUT against the model each cycle, then advance the model
  // using the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    obs_t act;
    act.st = state; act.rst = seq_reset; act.op = seq_operate;
    act.busy = busy; act.rd = run_done; act.ad = all_done;
    act.ab = aborted; act.rc = runs_completed;
    if (m_valid) begin
      n_checks++;
      if (act !== m_exp) begin
        n_errors++;
        $display("FAIL cycle_model cyc=%0d actual=%h expected=%h", cyc, act, m_exp);
      end
    end
    model_step();
  end

  // ---------------- event counters for literal checks ----------------
  int c_op, c_rst, c_gap, c_arm, c_rd, c_ad, c_ab, c_coinc, pr_cyc;
  logic pr_seen;

  always @(negedge clk) begin
    c_op    += int'(seq_operate);
    c_rst   += int'(seq_reset);
    c_gap   += int'(state == P_GAP);
    c_arm   += int'(state == P_ARM);
    c_rd    += int'(run_done);
    c_ad    += int'(all_done);
    c_ab    += int'(aborted);
    c_coinc += int'(run_done & all_done);
    if (state == P_PRERST && !pr_seen) begin
      pr_seen = 1'b1;
      pr_cyc  = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    c_op = 0; c_rst = 0; c_gap = 0; c_arm = 0; c_rd = 0; c_ad = 0;
    c_ab = 0; c_coinc = 0; pr_seen = 1'b0; pr_cyc = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (state !== P_IDLE && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(state), 32'(P_IDLE));
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] rl, input logic [CNT_W-1:0] gl,
                             input logic [REP_W-1:0] rep, input logic ut);
    run_length = rl; gap_length = gl; repeat_count = rep; use_trig = ut;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    reset = 1'b1; start = 0; abort = 0; trig_in = 0; use_trig = 0;
    run_length = 0; gap_length = 0; repeat_count = 0;
    clear_counts();
    repeat (3) tick();
    reset = 1'b0;
    check("reset_state", {29'd0, state}, 32'd0);
    check("reset_outputs", {26'd0, seq_reset, seq_operate, busy, run_done, all_done, aborted}, 32'd0);
    check("reset_runs", 32'(runs_completed), 32'd0);

    // Two runs with a gap; inputs changed after acceptance must not matter.
    clear_counts();
    pulse_start(5, 3, 2, 1'b0);
    run_length = 9; repeat_count = 5;
    wait_idle(200, "t1_timeout");
    repeat (2) tick();
    check("t1_operate_cycles", c_op, 10);
    check("t1_reset_cycles", c_rst, 4);
    check("t1_gap_cycles", c_gap, 3);
    check("t1_arm_cycles", c_arm, 2);
    check("t1_run_done", c_rd, 2);
    check("t1_all_done", c_ad, 1);
    check("t1_coincide", c_coinc, 1);
    check("t1_runs_completed", 32'(runs_completed), 2);
    check("t1_busy", 32'(busy), 0);

    // Trigger held high before start: the stale level must not start a run.
    clear_counts();
    trig_in = 1'b1;
    repeat (4) tick();
    pulse_start(4, 0, 1, 1'b1);
    repeat (6) tick();
    check("t2_stale_trig_arm", 32'(state), 32'(P_ARM));
    trig_in = 1'b0;
    tick();
    trig_in = 1'b1;
    n = cyc;
    wait_idle(100, "t2_timeout");
    repeat (2) tick();
    check("t2_trig_latency", pr_cyc - n, EXP_TRIG_LAT);
    check("t2_operate_cycles", c_op, 4);
    check("t2_run_done", c_rd, 1);

    // A one-cycle trigger pulse is still detected.
    clear_counts();
    trig_in = 1'b0;
    repeat (2) tick();
    pulse_start(2, 0, 1, 1'b1);
    repeat (3) tick();
    trig_in = 1'b1;
    n = cyc;
    tick();
    trig_in = 1'b0;
    wait_idle(100, "t2b_timeout");
    repeat (2) tick();
    check("t2b_trig_latency", pr_cyc - n, EXP_TRIG_LAT);
    check("t2b_operate_cycles", c_op, 2);

    // Endless runs with no gap, aborted during the third run.
    clear_counts();
    pulse_start(3, 0, 0, 1'b0);
    n = 0;
    while (!(state == P_RUN && runs_completed == 2) && n < 200) begin
      tick();
      n++;
    end
    check("t3_reach_third_run", 32'(n < 200), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_operate_off", 32'(seq_operate), 0);
    check("t3_aborted", 32'(aborted), 1);
    check("t3_state_idle", 32'(state), 32'(P_IDLE));
    check("t3_runs_completed", 32'(runs_completed), 2);
    repeat (3) tick();
    check("t3_no_all_done", c_ad, 0);
    check("t3_run_done", c_rd, 2);
    check("t3_abort_pulses", c_ab, 1);

    // Zero-length start is ignored; start with abort is ignored.
    clear_counts();
    pulse_start(0, 0, 1, 1'b0);
    repeat (3) tick();
    check("t4_zero_len_state", 32'(state), 32'(P_IDLE));
    check("t4_zero_len_busy", 32'(busy), 0);
    run_length = 3; abort = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    check("t4_start_abort_state", 32'(state), 32'(P_IDLE));
    check("t4_no_aborted", c_ab, 0);
    check("t4_no_pulses", c_rd + c_ad, 0);

    // Reset in the middle of a long run, followed by a full run.
    pulse_start(100, 0, 1, 1'b0);
    repeat (20) tick();
    check("t5_in_run", 32'(state), 32'(P_RUN));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_reset_outputs", {state, seq_reset, seq_operate, busy, run_done, all_done, aborted, runs_completed}, 0);
    clear_counts();
    pulse_start(100, 0, 1, 1'b0);
    wait_idle(300, "t5_timeout");
    repeat (2) tick();
    check("t5_operate_cycles", c_op, 100);
    check("t5_run_done", c_rd, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
